gate_op_arbiter: RTL and testbench

- Shares one registered bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters.
- Each requester presents two operands and an opcode and raises a request.
- A round-robin arbiter grants one requester, captures its operands, evaluates, and returns a tagged result through a valid/ready response handshake.
- Sits between the per-channel control logic and the single shared gate datapath, so N gate instances are not needed.

---
 rtl/gate_op_arbiter_if.sv | 34 +++
 rtl/gate_op_arbiter.sv | 129 ++++++++++++
 tb/tb_gate_op_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gate_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_op_arbiter_if
// Brief    : Request/operand bundle and tagged response handshake for the
//            shared gate-op arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface gate_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] op_a;
    logic [NUM_REQ*WIDTH-1:0] op_b;
    logic [NUM_REQ*2-1:0]     op_sel;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req, op_a, op_b, op_sel, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req, op_a, op_b, op_sel, rsp_ready,
        output gnt, busy, rsp_valid, rsp_data, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_op_arbiter
// Brief    : Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit
//            among NUM_REQ requesters, with a tagged valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
module gate_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input wire            clk,
    input wire            rst_n,
    gate_op_arbiter_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_winner;
    logic [ID_W-1:0]    w_pick;
    logic               w_any;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [1:0]         w_sel_op;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic [NUM_REQ-1:0] w_gnt;

    // Scan from the pointer upward; the ID_W-bit sum wraps since NUM_REQ is a power of two.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && bus.req[r_ptr + ID_W'(k)]) begin
                w_any  = 1'b1;
                w_pick = r_ptr + ID_W'(k);
            end
        end
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_winner == ID_W'(i)) begin
                w_sel_a  = bus.op_a[i*WIDTH +: WIDTH];
                w_sel_b  = bus.op_b[i*WIDTH +: WIDTH];
                w_sel_op = bus.op_sel[i*2 +: 2];
            end
        end
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            2'b00:   w_result = r_a & r_b;
            2'b01:   w_result = r_a | r_b;
            2'b10:   w_result = r_a ^ r_b;
            default: w_result = ~(r_a & r_b);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any) w_state_nxt = c_st_load;
            c_st_load: w_state_nxt = c_st_exec;
            c_st_exec: w_state_nxt = c_st_resp;
            c_st_resp: if (bus.rsp_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 2'b00;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_idle && w_any) begin
                r_winner <= w_pick;
            end
            if (r_state == c_st_load) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_op  <= w_sel_op;
                r_ptr <= r_winner + ID_W'(1);
            end
            if (r_state == c_st_exec) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= r_winner;
            end
        end
    end

    // Outputs decode straight from registered state so an async reset clears them at once.
    always_comb begin
        w_gnt = '0;
        if (r_state == c_st_load) begin
            w_gnt[r_winner] = 1'b1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.busy      = (r_state != c_st_idle);
    assign bus.rsp_valid = (r_state == c_st_resp);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_op_arbiter
// Brief    : Directed self-checking bench for gate_op_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gate_op_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    gate_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.op_a[idx*WIDTH +: WIDTH] = a;
        bus.op_b[idx*WIDTH +: WIDTH] = b;
        bus.op_sel[idx*2 +: 2]       = op;
    endtask

    // One full service with rsp_ready high; req must already be set.
    task automatic serve(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_data,
                         input logic [1:0] exp_id, input bit hold_req);
        tick();
        check_eq({tag, ":gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check_eq({tag, ":busy"}, 32'(bus.busy), 32'd1);
        if (!hold_req) bus.req = bus.req & ~exp_gnt;
        tick();
        check_eq({tag, ":gnt_exec"}, 32'(bus.gnt), 32'd0);
        tick();
        check_eq({tag, ":valid"}, 32'(bus.rsp_valid), 32'd1);
        check_eq({tag, ":data"}, 32'(bus.rsp_data), 32'(exp_data));
        check_eq({tag, ":id"}, 32'(bus.rsp_id), 32'(exp_id));
        tick();
        check_eq({tag, ":valid_off"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, ":idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req       = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sel    = '0;
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst:gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst:busy", 32'(bus.busy), 32'd0);
        check_eq("rst:valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst:data", 32'(bus.rsp_data), 32'd0);
        check_eq("rst:id", 32'(bus.rsp_id), 32'd0);
        rst_n = 1'b1;

        // Single request, AND
        set_op(0, 8'hF0, 8'h3C, 2'b00);
        bus.req = 4'b0001;
        serve("single", 4'b0001, 8'h30, 2'd0, 1'b0);

        // Opcode sweep on requester 2
        set_op(2, 8'hA5, 8'h0F, 2'b00); bus.req = 4'b0100; serve("and",  4'b0100, 8'h05, 2'd2, 1'b0);
        set_op(2, 8'hA5, 8'h0F, 2'b01); bus.req = 4'b0100; serve("or",   4'b0100, 8'hAF, 2'd2, 1'b0);
        set_op(2, 8'hA5, 8'h0F, 2'b10); bus.req = 4'b0100; serve("xor",  4'b0100, 8'hAA, 2'd2, 1'b0);
        set_op(2, 8'hA5, 8'h0F, 2'b11); bus.req = 4'b0100; serve("nand", 4'b0100, 8'hFA, 2'd2, 1'b0);

        // Pointer at 3: 0101 wraps to 0 first, then 2
        set_op(0, 8'h0F, 8'hFF, 2'b01);
        set_op(2, 8'h33, 8'h0F, 2'b10);
        set_op(3, 8'hFF, 8'h81, 2'b00);
        bus.req = 4'b0101;
        serve("wrap0", 4'b0001, 8'hFF, 2'd0, 1'b0);
        serve("wrap2", 4'b0100, 8'h3C, 2'd2, 1'b0);
        bus.req = 4'b1000;
        serve("srv3", 4'b1000, 8'h81, 2'd3, 1'b0);
        bus.req = 4'b1001;
        serve("skip0", 4'b0001, 8'hFF, 2'd0, 1'b0);
        serve("skip3", 4'b1000, 8'h81, 2'd3, 1'b0);

        // Fresh pointer, all requesting continuously: strict rotation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_op(0, 8'hF0, 8'hAA, 2'b00);
        set_op(1, 8'hC3, 8'h33, 2'b01);
        set_op(2, 8'h5A, 8'hFF, 2'b10);
        set_op(3, 8'h96, 8'h0F, 2'b11);
        bus.req = 4'b1111;
        serve("rr0", 4'b0001, 8'hA0, 2'd0, 1'b1);
        serve("rr1", 4'b0010, 8'hF3, 2'd1, 1'b1);
        serve("rr2", 4'b0100, 8'hA5, 2'd2, 1'b1);
        serve("rr3", 4'b1000, 8'hF9, 2'd3, 1'b1);
        serve("rr0b", 4'b0001, 8'hA0, 2'd0, 1'b1);
        serve("rr1b", 4'b0010, 8'hF3, 2'd1, 1'b1);

        // Backpressure: requester 2 next, hold RESP for 5 cycles
        bus.rsp_ready = 1'b0;
        tick();
        check_eq("bp:gnt", 32'(bus.gnt), 32'b0100);
        tick();
        tick();
        check_eq("bp:valid", 32'(bus.rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("bp:valid%0d", c), 32'(bus.rsp_valid), 32'd1);
            check_eq($sformatf("bp:data%0d", c), 32'(bus.rsp_data), 32'hA5);
            check_eq($sformatf("bp:id%0d", c), 32'(bus.rsp_id), 32'd2);
            check_eq($sformatf("bp:nognt%0d", c), 32'(bus.gnt), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("bp:accept", 32'(bus.rsp_valid), 32'd0);
        tick();
        check_eq("bp:next_gnt", 32'(bus.gnt), 32'b1000);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("bp:drain", 32'(bus.busy), 32'd0);

        // Async reset in EXEC, with pointer left at 1 beforehand
        set_op(0, 8'hFF, 8'h0F, 2'b00);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        tick();
        check_eq("ar:in_exec", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar:busy", 32'(bus.busy), 32'd0);
        check_eq("ar:gnt", 32'(bus.gnt), 32'd0);
        check_eq("ar:valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("ar:data", 32'(bus.rsp_data), 32'd0);
        check_eq("ar:id", 32'(bus.rsp_id), 32'd0);
        tick();
        check_eq("ar:held_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        set_op(0, 8'h3C, 8'h5A, 2'b10);
        set_op(1, 8'hC0, 8'h0C, 2'b01);
        bus.req = 4'b0011;
        serve("ar:ptr0", 4'b0001, 8'h66, 2'd0, 1'b0);
        serve("ar:req1", 4'b0010, 8'hCC, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
